// File: rtl/execute_csr_trap.sv
// Machine-mode CSR execute unit with trap/mret handling and 64-bit counters.
//
// Accepts one CSR instruction per cycle over a valid/ready request channel,
// updates CSR state at the accepting edge and returns the pre-write value one
// cycle later on a valid/ready response channel. Traps and mret act directly
// on mstatus/mepc/mcause. mcycle counts clocks, minstret counts retirements.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   csr_addr_i, csr_op_i     CSR address and operation (RW/RS/RC and imm forms)
//   rs1_data_i, zimm_i       register source / 5-bit immediate source
//   rob_tag_i                tag echoed on the response
//   resp_valid_o/resp_ready_i response handshake
//   resp_tag_o, resp_data_o  echoed tag and old CSR value
//   resp_exc_o, resp_ecause_o illegal-instruction indication (cause 2)
//   trap_valid_i, trap_pc_i, trap_cause_i  trap entry
//   mret_i                   trap return
//   retire_cnt_i             instructions retired this cycle
//   flush_i                  drops the pending response and any same-cycle request
//   trap_vec_o, mepc_o, mie_o architectural views for the front end
module execute_csr_trap #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 6,
  parameter int RETIRE_W = 2,
  localparam int CW      = $clog2(RETIRE_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [11:0]      csr_addr_i,
  input  logic [2:0]       csr_op_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [4:0]       zimm_i,
  input  logic [TAG_W-1:0] rob_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [XLEN-1:0]  resp_data_o,
  output logic             resp_exc_o,
  output logic [4:0]       resp_ecause_o,
  input  logic             trap_valid_i,
  input  logic [XLEN-1:0]  trap_pc_i,
  input  logic [XLEN-1:0]  trap_cause_i,
  input  logic             mret_i,
  input  logic [CW-1:0]    retire_cnt_i,
  input  logic             flush_i,
  output logic [XLEN-1:0]  trap_vec_o,
  output logic [XLEN-1:0]  mepc_o,
  output logic             mie_o
);

  localparam bit              IS32      = (XLEN == 32);
  localparam logic [XLEN-1:0] MPP_BITS  = XLEN'(32'h0000_1800);
  localparam logic [XLEN-1:0] EPC_MASK  = ~XLEN'(1);
  localparam logic [XLEN-1:0] TVEC_MASK = ~XLEN'(3);

  logic [XLEN-1:0] mstatus, mtvec, mscratch, mepc, mcause, satp;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] mstatus_trap, mstatus_mret;

  logic [XLEN-1:0] src, rdata, wdata;
  logic            addr_ok, wr_intent, exc, accept, wr_en, trap_ctl;
  logic            we_mstatus, we_mtvec, we_mscratch, we_mepc, we_mcause, we_satp;
  logic            we_cyc_lo, we_cyc_hi, we_ins_lo, we_ins_hi;

  logic             vld_p1, exc_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [XLEN-1:0]  data_p1;

  // Decode, read mux and write-value computation (request stage)
  always_comb begin
    src       = csr_op_i[2] ? XLEN'(zimm_i) : rs1_data_i;
    // Set/clear forms with a zero source are pure reads and may target RO CSRs.
    wr_intent = (csr_op_i[1:0] == 2'b01) || (src != '0);

    rdata   = '0;
    addr_ok = 1'b1;
    case (csr_addr_i)
      12'h300: rdata = mstatus;
      12'h305: rdata = mtvec;
      12'h340: rdata = mscratch;
      12'h341: rdata = mepc;
      12'h342: rdata = mcause;
      12'h180: rdata = satp;
      12'hB00, 12'hC00: rdata = mcycle[XLEN-1:0];
      12'hB02, 12'hC02: rdata = minstret[XLEN-1:0];
      12'hB80, 12'hC80: begin
        rdata   = XLEN'(mcycle[63:32]);
        addr_ok = IS32;
      end
      12'hB82, 12'hC82: begin
        rdata   = XLEN'(minstret[63:32]);
        addr_ok = IS32;
      end
      default: addr_ok = 1'b0;
    endcase

    case (csr_op_i[1:0])
      2'b10:   wdata = rdata | src;
      2'b11:   wdata = rdata & ~src;
      default: wdata = src;
    endcase

    exc = (csr_op_i[1:0] == 2'b00) || !addr_ok ||
          (wr_intent && (csr_addr_i[11:10] == 2'b11));

    mstatus_trap    = mstatus;
    mstatus_trap[7] = mstatus[3];
    mstatus_trap[3] = 1'b0;
    mstatus_mret    = mstatus;
    mstatus_mret[3] = mstatus[7];
    mstatus_mret[7] = 1'b1;
  end

  assign req_ready_o = !vld_p1 || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign wr_en       = accept && !flush_i && !exc && wr_intent;
  assign trap_ctl    = trap_valid_i || mret_i;

  assign we_mstatus  = wr_en && (csr_addr_i == 12'h300);
  assign we_mtvec    = wr_en && (csr_addr_i == 12'h305);
  assign we_mscratch = wr_en && (csr_addr_i == 12'h340);
  assign we_mepc     = wr_en && (csr_addr_i == 12'h341);
  assign we_mcause   = wr_en && (csr_addr_i == 12'h342);
  assign we_satp     = wr_en && (csr_addr_i == 12'h180);
  assign we_cyc_lo   = wr_en && (csr_addr_i == 12'hB00);
  assign we_cyc_hi   = wr_en && IS32 && (csr_addr_i == 12'hB80);
  assign we_ins_lo   = wr_en && (csr_addr_i == 12'hB02);
  assign we_ins_hi   = wr_en && IS32 && (csr_addr_i == 12'hB82);

  // CSR state update at the accepting edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus  <= MPP_BITS;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      satp     <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      // Trap and mret own mstatus/mepc/mcause for the cycle; CSR writes there are dropped.
      if (trap_valid_i) begin
        mstatus <= mstatus_trap;
        mepc    <= trap_pc_i & EPC_MASK;
        mcause  <= trap_cause_i;
      end else if (mret_i) begin
        mstatus <= mstatus_mret;
      end else begin
        if (we_mstatus) mstatus <= wdata | MPP_BITS;
        if (we_mepc)    mepc    <= wdata & EPC_MASK;
        if (we_mcause)  mcause  <= wdata;
      end
      if (we_mtvec)    mtvec    <= wdata & TVEC_MASK;
      if (we_mscratch) mscratch <= wdata;
      if (we_satp)     satp     <= wdata;

      // A write to either half replaces it and skips that cycle's increment.
      if (we_cyc_lo)      mcycle <= IS32 ? {mcycle[63:32], wdata[31:0]} : 64'(wdata);
      else if (we_cyc_hi) mcycle <= {wdata[31:0], mcycle[31:0]};
      else                mcycle <= mcycle + 64'd1;

      if (we_ins_lo)      minstret <= IS32 ? {minstret[63:32], wdata[31:0]} : 64'(wdata);
      else if (we_ins_hi) minstret <= {wdata[31:0], minstret[31:0]};
      else                minstret <= minstret + 64'(retire_cnt_i);
    end
  end

  // Response stage (p1)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
      exc_p1  <= 1'b0;
    end else if (accept && !flush_i) begin
      vld_p1  <= 1'b1;
      tag_p1  <= rob_tag_i;
      data_p1 <= rdata;
      exc_p1  <= exc;
    end else if (flush_i || resp_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign resp_valid_o  = vld_p1;
  assign resp_tag_o    = tag_p1;
  assign resp_data_o   = data_p1;
  assign resp_exc_o    = exc_p1;
  assign resp_ecause_o = exc_p1 ? 5'd2 : 5'd0;

  assign trap_vec_o = {mtvec[XLEN-1:2], 2'b00};
  assign mepc_o     = mepc;
  assign mie_o      = mstatus[3];

endmodule

// File: tb/tb_execute_csr_trap.sv
module tb_execute_csr_trap;
  localparam int XLEN = 32, TAG_W = 6, RETIRE_W = 2, CW = 2;

  logic             clk = 1'b0, rst_ni = 1'b0;
  logic             req_valid_i = 0, req_ready_o;
  logic [11:0]      csr_addr_i = '0;
  logic [2:0]       csr_op_i = '0;
  logic [XLEN-1:0]  rs1_data_i = '0;
  logic [4:0]       zimm_i = '0;
  logic [TAG_W-1:0] rob_tag_i = '0;
  logic             resp_valid_o, resp_ready_i = 1'b1;
  logic [TAG_W-1:0] resp_tag_o;
  logic [XLEN-1:0]  resp_data_o;
  logic             resp_exc_o;
  logic [4:0]       resp_ecause_o;
  logic             trap_valid_i = 0, mret_i = 0, flush_i = 0;
  logic [XLEN-1:0]  trap_pc_i = '0, trap_cause_i = '0;
  logic [CW-1:0]    retire_cnt_i = '0;
  logic [XLEN-1:0]  trap_vec_o, mepc_o;
  logic             mie_o;

  execute_csr_trap #(.XLEN(XLEN), .TAG_W(TAG_W), .RETIRE_W(RETIRE_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i), .rs1_data_i(rs1_data_i),
    .zimm_i(zimm_i), .rob_tag_i(rob_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_tag_o(resp_tag_o), .resp_data_o(resp_data_o),
    .resp_exc_o(resp_exc_o), .resp_ecause_o(resp_ecause_o),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .mret_i(mret_i), .retire_cnt_i(retire_cnt_i), .flush_i(flush_i),
    .trap_vec_o(trap_vec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: architectural CSR values and the one-deep response slot.
  logic [31:0] m_status, m_tvec, m_scratch, m_epc, m_cause, m_satp;
  logic [63:0] m_cyc, m_inst;
  logic        r_valid, r_exc;
  logic [5:0]  r_tag;
  logic [31:0] r_data;

  logic [11:0] addrs [17] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h180,
                              12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hB80, 12'hB82,
                              12'hC80, 12'hC82, 12'h7C0, 12'h301, 12'hF11};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status = 32'h1800; m_tvec = 0; m_scratch = 0; m_epc = 0; m_cause = 0; m_satp = 0;
    m_cyc = 0; m_inst = 0; r_valid = 0; r_exc = 0; r_tag = 0; r_data = 0;
  endtask

  function automatic void model_read(input logic [11:0] a, output logic ok, output logic [31:0] v);
    ok = 1'b1;
    case (a)
      12'h300: v = m_status;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h180: v = m_satp;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB02, 12'hC02: v = m_inst[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB82, 12'hC82: v = m_inst[63:32];
      default: begin ok = 1'b0; v = 0; end
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs being driven now.
  task automatic model_edge();
    logic [31:0] n_status, n_tvec, n_scratch, n_epc, n_cause, n_satp, src, old, nv;
    logic [63:0] n_cyc, n_inst;
    logic        ok, intent, exc, legal, busy;
    n_status = m_status; n_tvec = m_tvec; n_scratch = m_scratch;
    n_epc = m_epc; n_cause = m_cause; n_satp = m_satp;
    n_cyc = m_cyc + 64'd1;
    n_inst = m_inst + 64'(retire_cnt_i);
    busy = trap_valid_i || mret_i;
    if (req_valid_i && (!r_valid || resp_ready_i) && !flush_i) begin
      legal  = !(csr_op_i == 3'd0 || csr_op_i == 3'd4);
      src    = csr_op_i[2] ? {27'd0, zimm_i} : rs1_data_i;
      intent = (csr_op_i == 3'd1 || csr_op_i == 3'd5) || (src != 0);
      model_read(csr_addr_i, ok, old);
      exc = !legal || !ok || (intent && csr_addr_i[11:10] == 2'b11);
      if (!exc && intent) begin
        if (csr_op_i == 3'd1 || csr_op_i == 3'd5)      nv = src;
        else if (csr_op_i == 3'd2 || csr_op_i == 3'd6) nv = old | src;
        else                                           nv = old & ~src;
        case (csr_addr_i)
          12'h300: if (!busy) n_status = nv | 32'h1800;
          12'h305: n_tvec = nv & ~32'd3;
          12'h340: n_scratch = nv;
          12'h341: if (!busy) n_epc = nv & ~32'd1;
          12'h342: if (!busy) n_cause = nv;
          12'h180: n_satp = nv;
          12'hB00: n_cyc = {m_cyc[63:32], nv};
          12'hB80: n_cyc = {nv, m_cyc[31:0]};
          12'hB02: n_inst = {m_inst[63:32], nv};
          12'hB82: n_inst = {nv, m_inst[31:0]};
          default: ;
        endcase
      end
      r_valid = 1'b1; r_tag = rob_tag_i; r_data = old; r_exc = exc;
    end else if (flush_i || resp_ready_i) begin
      r_valid = 1'b0;
    end
    if (trap_valid_i) begin
      n_epc = trap_pc_i & ~32'd1;
      n_cause = trap_cause_i;
      n_status[7] = m_status[3];
      n_status[3] = 1'b0;
    end else if (mret_i) begin
      n_status[3] = m_status[7];
      n_status[7] = 1'b1;
    end
    m_status = n_status; m_tvec = n_tvec; m_scratch = n_scratch;
    m_epc = n_epc; m_cause = n_cause; m_satp = n_satp; m_cyc = n_cyc; m_inst = n_inst;
  endtask

  task automatic check_all();
    chk("req_ready", 64'(req_ready_o), 64'(!r_valid || resp_ready_i));
    chk("resp_valid", 64'(resp_valid_o), 64'(r_valid));
    if (r_valid) begin
      chk("resp_tag", 64'(resp_tag_o), 64'(r_tag));
      chk("resp_exc", 64'(resp_exc_o), 64'(r_exc));
      chk("resp_ecause", 64'(resp_ecause_o), r_exc ? 64'd2 : 64'd0);
      if (!r_exc) chk("resp_data", 64'(resp_data_o), 64'(r_data));
    end
    chk("trap_vec", 64'(trap_vec_o), 64'({m_tvec[31:2], 2'b00}));
    chk("mepc_o", 64'(mepc_o), 64'(m_epc));
    chk("mie_o", 64'(mie_o), 64'(m_status[3]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
    tick();
  endtask

  task automatic req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                     input logic [4:0] z, input logic [5:0] t);
    req_valid_i = 1'b1; csr_op_i = op; csr_addr_i = a; rs1_data_i = rs1;
    zimm_i = z; rob_tag_i = t;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] exp32, v0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp_data", 64'(resp_data_o), 64'd0);
    chk("rst_resp_tag", 64'(resp_tag_o), 64'd0);
    chk("rst_ecause", 64'(resp_ecause_o), 64'd0);
    chk("rst_mie", 64'(mie_o), 64'd0);
    model_reset();
    rst_ni = 1'b1;

    req(3'd1, 12'h340, 32'hDEADBEEF, 5'd0, 6'd5);
    chk("r025_tag", 64'(resp_tag_o), 64'd5);
    chk("r025_data0", 64'(resp_data_o), 64'd0);
    req(3'd2, 12'h340, 32'd0, 5'd0, 6'd6);
    chk("r025_data1", 64'(resp_data_o), 64'hDEADBEEF);
    req(3'd2, 12'h340, 32'd0, 5'd0, 6'd7);
    chk("r025_nowrite", 64'(resp_data_o), 64'hDEADBEEF);

    req(3'd1, 12'hC00, 32'd1, 5'd0, 6'd8);
    chk("r026_exc", 64'(resp_exc_o), 64'd1);
    chk("r026_ecause", 64'(resp_ecause_o), 64'd2);
    exp32 = m_cyc[31:0];
    req(3'd2, 12'hC00, 32'd0, 5'd0, 6'd9);
    chk("r026_noexc", 64'(resp_exc_o), 64'd0);
    chk("r026_cycle", 64'(resp_data_o), 64'(exp32));

    idle();
    resp_ready_i = 1'b0;
    req(3'd1, 12'h340, 32'h1234, 5'd0, 6'd10);
    req_valid_i = 1'b1; csr_op_i = 3'd2; csr_addr_i = 12'h340; rs1_data_i = 0; rob_tag_i = 6'd11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r027_stall_ready", 64'(req_ready_o), 64'd0);
      chk("r027_hold_tag", 64'(resp_tag_o), 64'd10);
      chk("r027_hold_data", 64'(resp_data_o), 64'hDEADBEEF);
    end
    resp_ready_i = 1'b1;
    #1;
    chk("r027_release", 64'(req_ready_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    chk("r027_next_tag", 64'(resp_tag_o), 64'd11);
    chk("r027_next_data", 64'(resp_data_o), 64'h1234);

    req(3'd1, 12'h300, 32'h1808, 5'd0, 6'd12);
    chk("r028_mie_set", 64'(mie_o), 64'd1);
    trap_valid_i = 1'b1; trap_pc_i = 32'h80000103; trap_cause_i = 32'hB;
    idle();
    trap_valid_i = 1'b0;
    chk("r028_mepc", 64'(mepc_o), 64'h80000102);
    chk("r028_mie_clr", 64'(mie_o), 64'd0);
    req(3'd2, 12'h342, 32'd0, 5'd0, 6'd13);
    chk("r028_mcause", 64'(resp_data_o), 64'hB);
    req(3'd2, 12'h300, 32'd0, 5'd0, 6'd14);
    chk("r028_mstatus_trap", 64'(resp_data_o), 64'h1880);
    mret_i = 1'b1;
    idle();
    mret_i = 1'b0;
    req(3'd2, 12'h300, 32'd0, 5'd0, 6'd15);
    chk("r028_mstatus_mret", 64'(resp_data_o), 64'h1888);

    req(3'd1, 12'hB00, 32'hFFFFFFFF, 5'd0, 6'd16);
    req(3'd1, 12'hB80, 32'd0, 5'd0, 6'd17);
    idle();
    req(3'd2, 12'hB80, 32'd0, 5'd0, 6'd18);
    chk("r029_mcycleh", 64'(resp_data_o), 64'd1);
    req(3'd2, 12'hB02, 32'd0, 5'd0, 6'd19);
    v0 = resp_data_o;
    retire_cnt_i = 2'd2;
    repeat (4) idle();
    retire_cnt_i = 2'd0;
    req(3'd2, 12'hB02, 32'd0, 5'd0, 6'd20);
    chk("r029_minstret", 64'(resp_data_o), 64'(v0 + 32'd8));

    flush_i = 1'b1;
    req(3'd1, 12'h305, 32'h100, 5'd0, 6'd21);
    flush_i = 1'b0;
    chk("r030_no_resp", 64'(resp_valid_o), 64'd0);
    chk("r030_mtvec", 64'(trap_vec_o), 64'd0);

    req(3'd5, 12'h305, 32'd0, 5'h13, 6'd22);
    chk("mtvec_lowbits", 64'(trap_vec_o), 64'h10);
    req(3'd1, 12'h341, 32'h3, 5'd0, 6'd23);
    req(3'd7, 12'h300, 32'd0, 5'h1F, 6'd24);
    req(3'd2, 12'h300, 32'd0, 5'd0, 6'd25);
    chk("mpp_sticky", 64'(resp_data_o & 32'h1800), 64'h1800);
    req(3'd0, 12'h340, 32'd1, 5'd0, 6'd26);
    chk("illegal_op0", 64'(resp_exc_o), 64'd1);
    req(3'd4, 12'h340, 32'd1, 5'd0, 6'd27);
    chk("illegal_op4", 64'(resp_exc_o), 64'd1);
    req(3'd2, 12'h7C0, 32'd0, 5'd0, 6'd28);
    chk("unsupported", 64'(resp_exc_o), 64'd1);
    req(3'd6, 12'hC82, 32'd0, 5'd0, 6'd29);
    chk("instreth_read", 64'(resp_exc_o), 64'd0);

    for (int n = 0; n < 400; n++) begin
      req_valid_i  = ($urandom_range(0, 3) != 0);
      resp_ready_i = ($urandom_range(0, 3) != 0);
      csr_op_i     = 3'($urandom_range(0, 7));
      csr_addr_i   = addrs[$urandom_range(0, 16)];
      rs1_data_i   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      zimm_i       = 5'($urandom_range(0, 31));
      rob_tag_i    = 6'($urandom_range(0, 63));
      flush_i      = ($urandom_range(0, 15) == 0);
      trap_valid_i = ($urandom_range(0, 19) == 0);
      mret_i       = ($urandom_range(0, 19) == 0);
      trap_pc_i    = $urandom;
      trap_cause_i = $urandom;
      retire_cnt_i = 2'($urandom_range(0, 2));
      tick();
    end
    req_valid_i = 0; flush_i = 0; trap_valid_i = 0; mret_i = 0; retire_cnt_i = 0;
    resp_ready_i = 1'b1;
    idle();

    trap_valid_i = 1'b1; trap_pc_i = 32'h4444; trap_cause_i = 32'h3;
    idle();
    trap_valid_i = 1'b0;
    req(3'd1, 12'h340, 32'h55, 5'd0, 6'd30);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 64'(resp_valid_o), 64'd0);
    chk("midrst_ready", 64'(req_ready_o), 64'd1);
    chk("midrst_mepc", 64'(mepc_o), 64'd0);
    chk("midrst_tag", 64'(resp_tag_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    req(3'd2, 12'h340, 32'd0, 5'd0, 6'd31);
    chk("midrst_scratch", 64'(resp_data_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_csr_trap.md
EXECUTE_CSR_TRAP -- requirements
Module: execute_csr_trap

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 and 64 are legal.
REQ-002 SHALL have parameter TAG_W, default 6, ROB tag width.
REQ-003 SHALL have parameter RETIRE_W, default 2, maximum instructions retired per cycle; CW = $clog2(RETIRE_W+1).
REQ-004 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: req_valid_i in 1; req_ready_o out 1; csr_addr_i in 12; csr_op_i in 3; rs1_data_i in XLEN; zimm_i in 5; rob_tag_i in TAG_W.
REQ-006 SHALL have ports: resp_valid_o out 1; resp_ready_i in 1; resp_tag_o out TAG_W; resp_data_o out XLEN; resp_exc_o out 1; resp_ecause_o out 5.
REQ-007 SHALL have ports: trap_valid_i in 1; trap_pc_i in XLEN; trap_cause_i in XLEN; mret_i in 1; retire_cnt_i in CW; flush_i in 1; trap_vec_o out XLEN; mepc_o out XLEN; mie_o out 1.

Function
REQ-008 csr_op_i encoding SHALL be: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000 and 100 are illegal.
REQ-009 Source SHALL be zero-extended zimm_i for RWI/RSI/RCI, rs1_data_i otherwise; RW/RWI SHALL always write; RS/RSI (old|src) and RC/RCI (old&~src) SHALL write only when src != 0.
REQ-010 Supported CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, satp 0x180, mcycle 0xB00, minstret 0xB02, cycle 0xC00 (RO), instret 0xC02 (RO); when XLEN=32 also mcycleh 0xB80, minstreth 0xB82, cycleh 0xC80 (RO), instreth 0xC82 (RO).
REQ-011 mcycle/minstret SHALL be 64-bit; XLEN=64 accesses at 0xB00/0xB02/0xC00/0xC02 SHALL return full value; XLEN=32 low/high halves per REQ-010; *h addresses SHALL be unsupported when XLEN=64.
REQ-012 Field rules: mtvec[1:0] and mepc[0] SHALL read 0 and ignore writes; mstatus bits 12:11 (MPP) SHALL read 2'b11 always; other mstatus bits fully writable.
REQ-013 Exception SHALL be raised (resp_exc_o=1, resp_ecause_o=2) for illegal op, unsupported address, or write intent (REQ-009) to address with csr_addr_i[11:10]=2'b11; no CSR state SHALL change then; resp_ecause_o SHALL be 0 otherwise.
REQ-014 Handshake: req_ready_o = !resp_valid_o || resp_ready_i; request accepted on valid&&ready edge.
REQ-015 Accepted request SHALL update CSR state at the accepting edge and present response the next cycle (latency 1); resp_data_o = pre-write value; resp_tag_o = rob_tag_i; response held stable until resp_ready_i.
REQ-016 Back-to-back accepted requests SHALL observe prior request's write.
REQ-017 flush_i SHALL clear resp_valid_o at the next edge and cancel any request accepted in the same cycle (no state change, no response); earlier completed writes are not undone.
REQ-018 Trap (trap_valid_i): mepc<=trap_pc_i with bit0 cleared, mcause<=trap_cause_i, MPIE(bit7)<=MIE(bit3), MIE<=0.
REQ-019 mret_i: MIE<=MPIE, MPIE<=1; trap_valid_i SHALL take priority over simultaneous mret_i.
REQ-020 Trap/mret updates SHALL override a same-cycle CSR write to mstatus/mepc/mcause; same-cycle writes to other CSRs SHALL proceed.
REQ-021 mcycle SHALL increment by 1 every cycle; minstret by retire_cnt_i; both wrap at 2^64; a same-cycle CSR write to any half SHALL replace that half and suppress that counter's increment that cycle.
REQ-022 trap_vec_o = {mtvec[XLEN-1:2],2'b00}; mepc_o = mepc; mie_o = mstatus[3]; all combinational from registers.

Reset
REQ-023 On rst_ni low: mstatus=0x1800, mtvec, mscratch, mepc, mcause, satp, mcycle, minstret = 0; resp_valid_o=0, resp_exc_o=0, resp_ecause_o=0, resp_tag_o=0, resp_data_o=0; req_ready_o=1.
REQ-024 Reset asserted mid-transaction SHALL discard pending response and all state immediately.

Verification
REQ-025 RW mscratch rs1=0xDEADBEEF tag 5, then RS mscratch rs1=0 -> responses tag 5 data 0, then data 0xDEADBEEF; no write on second.
REQ-026 RW cycle (0xC00) rs1=1 -> resp_exc_o=1, ecause 2; RS cycle rs1=0 -> no exception, data = current mcycle.
REQ-027 resp_ready_i=0 for 3 cycles after a response -> req_ready_o=0, response stable; release -> next request accepted same cycle.
REQ-028 mstatus=0x1808, trap_valid_i with pc 0x80000103, cause 0xB -> mepc 0x80000102, mcause 0xB, mstatus 0x1880, mie_o=0; then mret_i -> mstatus 0x1888.
REQ-029 XLEN=32: write mcycle=0xFFFFFFFF, mcycleh=0 -> two cycles later mcycleh reads 1; retire_cnt_i=2 for 4 cycles -> minstret +8.
REQ-030 Request accepted with flush_i=1 (RW mtvec 0x100) -> no response, mtvec unchanged.
